// File: rtl/flash_spi_arbiter.sv
// N-master arbiter and pad mux for the shared quad-SPI flash. It registers a
// one-hot grant, parks the bus for a guard gap between owners, and revokes a
// grant that runs too long. The revoked master stays locked out until it drops req.
module flash_spi_arbiter #(
  parameter int N_MASTERS      = 3,
  parameter int PRIO_MODE      = 0,
  parameter int GUARD_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int IW             = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_MASTERS-1:0]   req_i,
  output logic [N_MASTERS-1:0]   grant_o,
  input  logic [N_MASTERS-1:0]   m_sclk_i,
  input  logic [N_MASTERS-1:0]   m_cs_n_i,
  input  logic [4*N_MASTERS-1:0] m_sio_i,
  input  logic [4*N_MASTERS-1:0] m_oe_i,
  output logic [4*N_MASTERS-1:0] m_sio_o,
  output logic                   flash_sclk_o,
  output logic                   flash_cs_n_o,
  output logic [3:0]             flash_sio_o,
  output logic [3:0]             flash_oe_o,
  input  logic [3:0]             flash_sio_i,
  output logic                   busy_o,
  output logic [IW-1:0]          owner_o,
  output logic                   timeout_o
);

  typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

  localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  GUARD_LAST = 8'(GUARD_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [N_MASTERS-1:0]   grant_q, grant_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic                   tmo_q, tmo_d;
  logic [N_MASTERS-1:0]   lock_q, lock_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [31:0]            gcnt_q, gcnt_d;
  logic [7:0]             gdcnt_q, gdcnt_d;

  logic [N_MASTERS-1:0]   elig;
  logic                   found;
  logic [IW-1:0]          win;
  int unsigned            idx;
  logic                   owner_req;
  logic                   route;

  assign elig      = req_i & ~lock_q;
  assign owner_req = |(grant_q & req_i);
  // A master that drops req loses the pads that same cycle, even though grant_o lags by one edge.
  assign route     = (state_q == GRANT) && owner_req && !rst;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      idx = ((PRIO_MODE != 0) ? i : (int'(ptr_q) + i)) % N_MASTERS;
      if (!found && elig[idx[IW-1:0]]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    tmo_d   = 1'b0;
    lock_d  = lock_q & req_i;
    ptr_d   = ptr_q;
    gcnt_d  = gcnt_q;
    gdcnt_d = gdcnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = GRANT;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          owner_d      = win;
          ptr_d        = (win == IW'(N_MASTERS - 1)) ? '0 : win + 1'b1;
          gcnt_d       = '0;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_d = GUARD;
          grant_d = '0;
          gdcnt_d = '0;
        end else if ((TIMEOUT_CYCLES != 0) && (gcnt_q == TMO_LAST)) begin
          state_d = GUARD;
          grant_d = '0;
          gdcnt_d = '0;
          tmo_d   = 1'b1;
          lock_d  = lock_d | grant_q;
        end else if (gcnt_q != '1) begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      GUARD: begin
        if (gdcnt_q == GUARD_LAST) state_d = IDLE;
        else                       gdcnt_d = gdcnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      tmo_q   <= 1'b0;
      lock_q  <= '0;
      ptr_q   <= '0;
      gcnt_q  <= '0;
      gdcnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      tmo_q   <= tmo_d;
      lock_q  <= lock_d;
      ptr_q   <= ptr_d;
      gcnt_q  <= gcnt_d;
      gdcnt_q <= gdcnt_d;
    end
  end

  always_comb begin
    flash_sclk_o = 1'b0;
    flash_cs_n_o = 1'b1;
    flash_sio_o  = '0;
    flash_oe_o   = '0;
    m_sio_o      = '0;
    if (route) begin
      for (int unsigned k = 0; k < N_MASTERS; k++) begin
        if (grant_q[k]) begin
          flash_sclk_o       = m_sclk_i[k];
          flash_cs_n_o       = m_cs_n_i[k];
          flash_sio_o        = m_sio_i[4*k +: 4];
          flash_oe_o         = m_oe_i[4*k +: 4];
          m_sio_o[4*k +: 4]  = flash_sio_i;
        end
      end
    end
  end

  assign grant_o   = grant_q;
  assign owner_o   = owner_q;
  assign timeout_o = tmo_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_flash_spi_arbiter.sv
// Directed bench: round-robin/timeout instance (a) and fixed-priority,
// timeout-disabled instance (b), sharing clock, reset and master pad data.
module tb_flash_spi_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  req_a, req_b;
  logic [2:0]  m_sclk, m_cs_n;
  logic [11:0] m_sio, m_oe;
  logic [3:0]  fsio_in;

  logic [2:0]  grant_a, grant_b;
  logic [11:0] msio_a, msio_b;
  logic        sclk_a, sclk_b, cs_a, cs_b, busy_a, busy_b, tmo_a, tmo_b;
  logic [3:0]  sio_a, sio_b, oe_a, oe_b;
  logic [1:0]  owner_a, owner_b;

  int n_tests = 0;
  int n_fail  = 0;

  flash_spi_arbiter #(.N_MASTERS(3), .PRIO_MODE(0), .GUARD_CYCLES(4), .TIMEOUT_CYCLES(16)) dut_a (
    .clk(clk), .rst(rst), .req_i(req_a), .grant_o(grant_a),
    .m_sclk_i(m_sclk), .m_cs_n_i(m_cs_n), .m_sio_i(m_sio), .m_oe_i(m_oe), .m_sio_o(msio_a),
    .flash_sclk_o(sclk_a), .flash_cs_n_o(cs_a), .flash_sio_o(sio_a), .flash_oe_o(oe_a),
    .flash_sio_i(fsio_in), .busy_o(busy_a), .owner_o(owner_a), .timeout_o(tmo_a)
  );

  flash_spi_arbiter #(.N_MASTERS(3), .PRIO_MODE(1), .GUARD_CYCLES(4), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .req_i(req_b), .grant_o(grant_b),
    .m_sclk_i(m_sclk), .m_cs_n_i(m_cs_n), .m_sio_i(m_sio), .m_oe_i(m_oe), .m_sio_o(msio_b),
    .flash_sclk_o(sclk_b), .flash_cs_n_o(cs_b), .flash_sio_o(sio_b), .flash_oe_o(oe_b),
    .flash_sio_i(fsio_in), .busy_o(busy_b), .owner_o(owner_b), .timeout_o(tmo_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] sio_of(input int k);
    case (k)
      0:       return 4'hA;
      1:       return 4'hB;
      default: return 4'hC;
    endcase
  endfunction

  task automatic wait_grant_a(output int parked);
    int c;
    c      = 0;
    parked = 0;
    while (grant_a == 3'b000 && c < 60) begin
      if (cs_a) parked++;
      tick();
      c++;
    end
  endtask

  task automatic wait_idle_a();
    int c;
    c = 0;
    while (busy_a && c < 20) begin
      tick();
      c++;
    end
    check("idle_reached", busy_a, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int parked, exp, t, bad, c;
    rst     = 1'b1;
    req_a   = '0;
    req_b   = '0;
    m_sclk  = 3'b101;
    m_cs_n  = 3'b000;
    m_sio   = 12'hCBA;
    m_oe    = 12'hC3F;
    fsio_in = 4'h5;
    repeat (2) tick();

    // reset state
    check("rst_grant", grant_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_owner", owner_a, 0);
    check("rst_tmo", tmo_a, 0);
    check("rst_cs_n", cs_a, 1);
    check("rst_oe", oe_a, 0);
    check("rst_sclk", sclk_a, 0);
    check("rst_msio", msio_a, 0);
    check("rst_grant_b", grant_b, 0);
    rst = 1'b0;
    tick();

    // round robin with everyone requesting
    req_a = 3'b111;
    for (int g = 0; g < 4; g++) begin
      wait_grant_a(parked);
      exp = g % 3;
      check("rr_grant", grant_a, 1 << exp);
      check("rr_owner", owner_a, exp);
      if (g > 0) check("rr_guard_gap", parked >= 4, 1);
      check("rr_sio", sio_a, sio_of(exp));
      check("rr_msio", msio_a, 12'h5 << (4 * exp));
      repeat (10) tick();
      req_a[exp] = 1'b0;
      tick();
      if (g < 3) req_a[exp] = 1'b1;
      else       req_a = '0;
    end
    wait_idle_a();

    // data path, owner 0
    req_a = 3'b001;
    #1;
    check("dp_parked_idle", cs_a, 1);
    tick();
    check("dp_grant", grant_a, 3'b001);
    check("dp_busy", busy_a, 1);
    check("dp_owner", owner_a, 0);
    check("dp_sio", sio_a, 4'hA);
    check("dp_oe", oe_a, 4'hF);
    check("dp_sclk", sclk_a, 1);
    check("dp_cs_n", cs_a, 0);
    check("dp_msio", msio_a, 12'h005);
    req_a = 3'b000;
    #1;
    check("rel_cs_n", cs_a, 1);
    check("rel_oe", oe_a, 0);
    check("rel_sio", sio_a, 0);
    check("rel_msio", msio_a, 0);
    check("rel_grant_lag", grant_a, 3'b001);
    tick();
    check("rel_grant", grant_a, 0);
    check("guard_busy0", busy_a, 1);
    repeat (3) tick();
    check("guard_busy3", busy_a, 1);
    tick();
    check("guard_end", busy_a, 0);
    check("owner_hold", owner_a, 0);

    // timeout and lockout on master 1
    req_a = 3'b010;
    tick();
    check("to_grant", grant_a, 3'b010);
    t = 0;
    while (!tmo_a && t < 40) begin
      tick();
      t++;
    end
    check("to_latency", t, 16);
    check("to_grant_off", grant_a, 0);
    check("to_cs_n", cs_a, 1);
    check("to_busy", busy_a, 1);
    tick();
    t++;
    check("to_pulse_width", tmo_a, 0);
    bad = 0;
    while (t < 40) begin
      tick();
      t++;
      if (grant_a != 3'b000) bad++;
    end
    check("lockout_no_regrant", bad, 0);
    check("lockout_idle", busy_a, 0);
    req_a = 3'b000;
    tick();
    req_a = 3'b010;
    tick();
    check("regrant_after_toggle", grant_a, 3'b010);
    req_a = 3'b000;
    tick();
    wait_idle_a();

    // release on the same cycle the timeout would fire
    req_a = 3'b100;
    tick();
    check("tr_grant", grant_a, 3'b100);
    repeat (15) tick();
    req_a = 3'b000;
    #1;
    check("tr_cs_n", cs_a, 1);
    tick();
    check("tr_no_tmo", tmo_a, 0);
    check("tr_grant_off", grant_a, 0);
    check("tr_busy", busy_a, 1);
    repeat (3) tick();
    check("tr_guard3", busy_a, 1);
    tick();
    check("tr_guard_end", busy_a, 0);
    req_a = 3'b100;
    tick();
    check("tr_no_lockout", grant_a, 3'b100);
    check("tr_owner", owner_a, 2);

    // reset mid-grant
    rst = 1'b1;
    #1;
    check("rstm_cs_n_now", cs_a, 1);
    check("rstm_oe_now", oe_a, 0);
    tick();
    check("rstm_grant", grant_a, 0);
    check("rstm_busy", busy_a, 0);
    check("rstm_owner", owner_a, 0);
    check("rstm_tmo", tmo_a, 0);
    rst = 1'b0;
    #1;
    check("rstm_no_early", grant_a, 0);
    tick();
    check("rstm_rearb", grant_a, 3'b100);
    req_a = 3'b000;
    tick();
    wait_idle_a();

    // fixed priority, no pre-emption, timeout disabled
    req_b = 3'b100;
    tick();
    check("fp_grant2", grant_b, 3'b100);
    repeat (2) tick();
    req_b = 3'b110;
    repeat (3) tick();
    req_b = 3'b111;
    bad = 0;
    repeat (25) begin
      tick();
      if (grant_b != 3'b100 || tmo_b) bad++;
    end
    check("fp_no_preempt", bad, 0);
    req_b = 3'b011;
    c = 0;
    while (grant_b != 3'b001 && c < 20) begin
      tick();
      c++;
    end
    check("fp_grant0_first", grant_b, 3'b001);
    check("fp_owner0", owner_b, 0);
    repeat (5) tick();
    req_b = 3'b010;
    c = 0;
    while (grant_b != 3'b010 && c < 20) begin
      tick();
      c++;
    end
    check("fp_grant1", grant_b, 3'b010);
    req_b = 3'b000;
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
